// File: rtl/alu_logic_serial_pkg.sv
// Shared definitions for the serial bitwise logic unit.
//   - op codes for the six supported operations (110 and 111 are illegal)
//   - FSM state encoding used by the top level
package alu_logic_serial_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_logic_serial_chunk.sv
// Combinational bitwise operation on one CHUNK-bit slice.
// Ports:
//   op      in   3      operation select
//   a, b    in   CHUNK  operand slices
//   y       out  CHUNK  result slice (0 for an illegal op)
//   illegal out  1      op is not one of the six supported codes
module alu_logic_serial_chunk
  import alu_logic_serial_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [2:0]       op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y,
  output logic             illegal
);

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logic_serial.sv
// Multi-cycle bitwise logic unit: computes f(op, a, b) CHUNK bits per clock,
// least-significant chunk first, then presents result/zero/err until taken.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low; ready never depends on valid.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (op, a, b); in_ready only in IDLE
//   out_valid/out_ready   result handshake (result, zero, err); valid in DONE
//   result                WIDTH-bit bitwise result
//   zero                  result == 0
//   err                   op code was illegal (result forced to 0)
module alu_logic_serial
  import alu_logic_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [CHUNK-1:0] chunk_y;
  logic             chunk_illegal;

  alu_logic_serial_chunk #(.CHUNK(CHUNK)) u_chunk (
    .op      (op_q),
    .a       (a_q[count_q*CHUNK +: CHUNK]),
    .b       (b_q[count_q*CHUNK +: CHUNK]),
    .y       (chunk_y),
    .illegal (chunk_illegal)
  );

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d     = op;
          a_d      = a;
          b_d      = b;
          count_d  = '0;
          result_d = '0;
          zero_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        result_d[count_q*CHUNK +: CHUNK] = chunk_y;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          // Flags look at result_d so the chunk written on this edge counts.
          zero_d  = (result_d == '0);
          err_d   = chunk_illegal;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_logic_serial.sv
module tb_alu_logic_serial;

  localparam int W      = 32;
  localparam int NCHUNK = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  alu_logic_serial #(.WIDTH(W), .CHUNK(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {err, zero, result} expected, and cycle of each accept edge
  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // reference model: whole-word operators straight from the op table
  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         e;
    e = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = ~(x & y);
      3'd2: r = x | y;
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      3'd5: r = ~(x ^ y);
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, (r == '0), r};
  endfunction

  // out_ready driver, changes just after the active edge
  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (ready_mode == 1);
  end

  // monitor: latency, hold stability, and result comparison on handshake
  logic         prev_valid = 1'b0;
  logic         hold_pending = 1'b0;
  logic [W+1:0] held;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid   = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("unexpected_out_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - acc_q[0]), 64'(NCHUNK));
      end
      if (out_valid) begin
        if (hold_pending) check("hold_stable", 64'({err, zero, result}), 64'(held));
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
          else begin
            check("result_flags", 64'({err, zero, result}), 64'(exp_q.pop_front()));
            void'(acc_q.pop_front());
          end
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          held = {err, zero, result};
        end
      end else hold_pending = 1'b0;
      prev_valid = out_valid;
    end
  end

  // driver: present operands, wait for in_ready, record expectation at accept
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(o, x, y));
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({zero, err}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // 1. NOR
    ready_mode = 1;
    send(3'b011, 32'h0000FFFF, 32'h00FF00FF);
    wait_drain();
    // 2. AND giving zero
    send(3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F);
    wait_drain();

    // 3. XOR with consumer stalled; extra in_valid must be ignored
    ready_mode = 0;
    @(posedge clk); #1;
    send(3'b100, 32'hFFFFFFFF, 32'h12345678);
    wait_out_valid();
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'b000; a = $urandom; b = $urandom;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ready_mode = 1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4. illegal op
    send(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_drain();

    // 5. OR abandoned by reset after two BUSY cycles
    send(3'b010, 32'h12340000, 32'h00005678);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    send(3'b101, 32'h0, 32'h0);
    wait_drain();

    // 6. back-to-back
    send(3'b001, 32'hFFFF0000, 32'hFF00FF00);
    send(3'b010, 32'h00000001, 32'h00000002);
    wait_drain();

    // random ops with random consumer back-pressure
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = $urandom;
      if (i % 7 == 0) y = x;
      if (i % 11 == 0) y = ~x;
      send(3'($urandom_range(0, 7)), x, y);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
